// File: rtl/wb_arbiter.sv
// wb_arbiter
// Shares the single register-file write port among N_REQ execution units.
// A round-robin arbiter picks one valid request per cycle and loads it into a
// registered writeback stage. The stage drives the register-file write port
// and the pending-table free port, so a busy bit clears on the same edge the
// result is written.
//
// Unit indices: 0 = ALU, 1 = MUL/DIV, 2 = MEM.
// Register r0 is hard-wired: requests for r0 complete the handshake but never
// assert rf_we. Freeing r0 is the idle no-op value on free_rn.

module wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int DATA_W = 64,
    parameter int RN_W   = 7
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic [N_REQ-1:0]         req_valid,
    output logic [N_REQ-1:0]         req_ready,
    input  logic [N_REQ*RN_W-1:0]    req_rn,
    input  logic [N_REQ*DATA_W-1:0]  req_data,

    input  logic                     wb_stall,

    output logic                     rf_we,
    output logic [RN_W-1:0]          rf_wa,
    output logic [DATA_W-1:0]        rf_wd,

    output logic [RN_W-1:0]          free_rn
);

    localparam int RR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    // Candidate index arithmetic needs one spare bit so rr + offset cannot
    // overflow before the wrap-around subtraction.
    localparam logic [RR_W:0]   N_REQ_X = (RR_W+1)'(N_REQ);
    localparam logic [RR_W-1:0] RR_LAST = RR_W'(N_REQ - 1);

    logic                 out_valid;
    logic [RN_W-1:0]      out_rn;
    logic [DATA_W-1:0]    out_data;
    logic [RR_W-1:0]      rr;

    logic                 can_accept;
    logic [N_REQ-1:0]     win;
    logic [RR_W-1:0]      win_idx;
    logic                 found;
    logic [RR_W:0]        cand;
    logic [RN_W-1:0]      sel_rn;
    logic [DATA_W-1:0]    sel_data;
    logic                 transfer;

    // The stage can take a new result when it is empty or draining this cycle.
    // Holding ready low during reset keeps a handshake from being lost while
    // the stage is forced empty.
    assign can_accept = rst_n & (~out_valid | ~wb_stall);

    // Round-robin search: scan upward from rr with wrap-around, first valid wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = {1'b0, rr} + (RR_W+1)'(k);
            if (cand >= N_REQ_X) begin
                cand = cand - N_REQ_X;
            end
            if (!found && req_valid[cand[RR_W-1:0]]) begin
                found                 = 1'b1;
                win[cand[RR_W-1:0]]   = 1'b1;
                win_idx               = cand[RR_W-1:0];
            end
        end
    end

    assign req_ready = win & {N_REQ{can_accept}};
    assign transfer  = |req_ready;

    // One-hot select of the winning unit's destination register and result.
    always_comb begin
        sel_rn   = '0;
        sel_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (win[i]) begin
                sel_rn   = sel_rn   | req_rn[i*RN_W +: RN_W];
                sel_data = sel_data | req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Pointer moves just past the granted unit; holds when nothing transfers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= '0;
        end else if (transfer) begin
            rr <= (win_idx == RR_LAST) ? '0 : win_idx + 1'b1;
        end
    end

    // Writeback stage: refill on a transfer, drain when the port is free,
    // otherwise hold the pending result through the stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_rn    <= '0;
            out_data  <= '0;
        end else if (transfer) begin
            out_valid <= 1'b1;
            out_rn    <= sel_rn;
            out_data  <= sel_data;
        end else if (!wb_stall) begin
            out_valid <= 1'b0;
        end
    end

    assign rf_we   = out_valid & (out_rn != '0);
    assign rf_wa   = out_rn;
    assign rf_wd   = out_data;
    assign free_rn = (out_valid & ~wb_stall) ? out_rn : '0;

    // At most one unit is ever granted, and the pointer stays in range.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ($onehot0(req_ready))
                else $error("wb_arbiter: more than one req_ready asserted");
            assert (rr <= RR_LAST)
                else $error("wb_arbiter: round-robin pointer out of range");
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later,
// well away from the rising edge where state updates.

module tb_wb_arbiter;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int RW = 7;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*RW-1:0]   req_rn;
    logic [N*DW-1:0]   req_data;
    logic              wb_stall;
    logic              rf_we;
    logic [RW-1:0]     rf_wa;
    logic [DW-1:0]     rf_wd;
    logic [RW-1:0]     free_rn;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter #(.N_REQ(N), .DATA_W(DW), .RN_W(RW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_rn    (req_rn),
        .req_data  (req_data),
        .wb_stall  (wb_stall),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .free_rn   (free_rn)
    );

    // 10-unit clock period.
    always #5 clk = ~clk;

    task automatic set_req(input int i, input logic [RW-1:0] rn, input logic [DW-1:0] d);
        req_rn[i*RW +: RW]   = rn;
        req_data[i*DW +: DW] = d;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = '0;
        wb_stall  = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_rn    = '0;
        req_data  = '0;
        wb_stall  = 1'b0;
        #2;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we got %0b want 0", rf_we); end
        n_checks++; if (rf_wa !== 7'd0) begin n_fail++; $display("FAIL reset_rf_wa got %0d want 0", rf_wa); end
        n_checks++; if (rf_wd !== 64'd0) begin n_fail++; $display("FAIL reset_rf_wd got %0h want 0", rf_wd); end
        n_checks++; if (free_rn !== 7'd0) begin n_fail++; $display("FAIL reset_free_rn got %0d want 0", free_rn); end
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
        @(negedge clk);
        rst_n = 1'b1;

        // Load the stage from unit 1 so rr moves to 2, then reset mid-stream.
        @(negedge clk);
        req_valid = 3'b010;
        set_req(1, 7'd4, 64'h44);
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL midrst_pre_ready got %b want 010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL midrst_loaded_we got %0b want 1", rf_we); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL midrst_rf_we got %0b want 0", rf_we); end
        n_checks++; if (free_rn !== 7'd0) begin n_fail++; $display("FAIL midrst_free_rn got %0d want 0", free_rn); end
        n_checks++; if (rf_wa !== 7'd0) begin n_fail++; $display("FAIL midrst_rf_wa got %0d want 0", rf_wa); end
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL midrst_req_ready got %b want 000", req_ready); end

        // First grant after release goes to unit 0.
        @(negedge clk);
        rst_n     = 1'b1;
        req_valid = 3'b111;
        set_req(0, 7'd1, 64'h10);
        set_req(1, 7'd2, 64'h20);
        set_req(2, 7'd3, 64'h30);
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL postrst_grant got %b want 001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_wa !== 7'd1) begin n_fail++; $display("FAIL postrst_rf_wa got %0d want 1", rf_wa); end
        n_checks++; if (rf_wd !== 64'h10) begin n_fail++; $display("FAIL postrst_rf_wd got %0h want 10", rf_wd); end
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        req_valid = 3'b010;
        set_req(1, 7'd5, 64'hDEAD);
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL single_ready got %b want 010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_we !== 1'b1) begin n_fail++; $display("FAIL single_rf_we got %0b want 1", rf_we); end
        n_checks++; if (rf_wa !== 7'd5) begin n_fail++; $display("FAIL single_rf_wa got %0d want 5", rf_wa); end
        n_checks++; if (rf_wd !== 64'hDEAD) begin n_fail++; $display("FAIL single_rf_wd got %0h want dead", rf_wd); end
        n_checks++; if (free_rn !== 7'd5) begin n_fail++; $display("FAIL single_free_rn got %0d want 5", free_rn); end
        @(negedge clk);
        #1;
        n_checks++; if (free_rn !== 7'd0) begin n_fail++; $display("FAIL single_free_idle got %0d want 0", free_rn); end
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL single_we_idle got %0b want 0", rf_we); end
        n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL single_ready_idle got %b want 000", req_ready); end
    endtask

    task automatic test_round_robin();
        logic [2:0]    exp_ready;
        logic [RW-1:0] exp_wa;
        apply_reset();
        @(negedge clk);
        set_req(0, 7'd1, 64'h100);
        set_req(1, 7'd2, 64'h101);
        set_req(2, 7'd3, 64'h102);
        req_valid = 3'b111;
        for (int c = 0; c < 6; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_ready = 3'b001 << (c % 3);
            n_checks++;
            if (req_ready !== exp_ready) begin
                n_fail++; $display("FAIL rr_grant cycle %0d got %b want %b", c, req_ready, exp_ready);
            end
            if (c > 0) begin
                exp_wa = RW'(((c - 1) % 3) + 1);
                n_checks++;
                if (rf_wa !== exp_wa || rf_we !== 1'b1) begin
                    n_fail++; $display("FAIL rr_wa cycle %0d got %0d/we=%0b want %0d/we=1", c, rf_wa, rf_we, exp_wa);
                end
            end
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_wa !== 7'd3) begin n_fail++; $display("FAIL rr_last_wa got %0d want 3", rf_wa); end
        n_checks++; if (rf_wd !== 64'h102) begin n_fail++; $display("FAIL rr_last_wd got %0h want 102", rf_wd); end
    endtask

    task automatic test_stall();
        apply_reset();
        @(negedge clk);
        req_valid = 3'b001;
        set_req(0, 7'd7, 64'h77);
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL stall_load_ready got %b want 001", req_ready); end
        @(negedge clk);
        req_valid = 3'b100;
        set_req(2, 7'd9, 64'h99);
        wb_stall  = 1'b1;
        for (int s = 0; s < 3; s++) begin
            if (s > 0) @(negedge clk);
            #1;
            n_checks++; if (req_ready !== 3'b000) begin n_fail++; $display("FAIL stall_ready cycle %0d got %b want 000", s, req_ready); end
            n_checks++; if (free_rn !== 7'd0) begin n_fail++; $display("FAIL stall_free cycle %0d got %0d want 0", s, free_rn); end
            n_checks++; if (rf_wa !== 7'd7 || rf_we !== 1'b1) begin n_fail++; $display("FAIL stall_hold cycle %0d got %0d/we=%0b want 7/we=1", s, rf_wa, rf_we); end
        end
        @(negedge clk);
        wb_stall = 1'b0;
        #1;
        n_checks++; if (free_rn !== 7'd7) begin n_fail++; $display("FAIL stall_release_free got %0d want 7", free_rn); end
        n_checks++; if (req_ready !== 3'b100) begin n_fail++; $display("FAIL stall_release_ready got %b want 100", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_wa !== 7'd9 || rf_wd !== 64'h99) begin n_fail++; $display("FAIL stall_next_wb got %0d/%0h want 9/99", rf_wa, rf_wd); end
        n_checks++; if (free_rn !== 7'd9) begin n_fail++; $display("FAIL stall_next_free got %0d want 9", free_rn); end

        // Stage is empty now: a stalled port still lets one request in.
        @(negedge clk);
        wb_stall  = 1'b1;
        req_valid = 3'b010;
        set_req(1, 7'd11, 64'hB);
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL empty_stall_we got %0b want 0", rf_we); end
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL empty_stall_ready got %b want 010", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_wa !== 7'd11 || rf_we !== 1'b1) begin n_fail++; $display("FAIL empty_stall_loaded got %0d/we=%0b want 11/we=1", rf_wa, rf_we); end
        n_checks++; if (free_rn !== 7'd0) begin n_fail++; $display("FAIL empty_stall_free got %0d want 0", free_rn); end
        @(negedge clk);
        wb_stall = 1'b0;
        #1;
        n_checks++; if (free_rn !== 7'd11) begin n_fail++; $display("FAIL empty_stall_release got %0d want 11", free_rn); end
        @(negedge clk);
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL empty_stall_drained got %0b want 0", rf_we); end
    endtask

    task automatic test_r0();
        apply_reset();
        @(negedge clk);
        req_valid = 3'b001;
        set_req(0, 7'd0, 64'h123);
        #1;
        n_checks++; if (req_ready !== 3'b001) begin n_fail++; $display("FAIL r0_ready got %b want 001", req_ready); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL r0_rf_we got %0b want 0", rf_we); end
        n_checks++; if (free_rn !== 7'd0) begin n_fail++; $display("FAIL r0_free got %0d want 0", free_rn); end
        n_checks++; if (rf_wd !== 64'h123) begin n_fail++; $display("FAIL r0_rf_wd got %0h want 123", rf_wd); end
    endtask

    task automatic test_fairness();
        logic [2:0] exp_seq [4];
        exp_seq[0] = 3'b001;
        exp_seq[1] = 3'b100;
        exp_seq[2] = 3'b001;
        exp_seq[3] = 3'b100;
        apply_reset();
        @(negedge clk);
        set_req(0, 7'd1, 64'hA0);
        set_req(2, 7'd3, 64'hC0);
        req_valid = 3'b101;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            n_checks++;
            if (req_ready !== exp_seq[c]) begin
                n_fail++; $display("FAIL fair_grant cycle %0d got %b want %b", c, req_ready, exp_seq[c]);
            end
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_wa !== 7'd3 || rf_wd !== 64'hC0) begin n_fail++; $display("FAIL fair_last_wb got %0d/%0h want 3/c0", rf_wa, rf_wd); end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        @(negedge clk);
        req_valid = 3'b010;
        set_req(1, 7'd6, 64'hA);
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL b2b_first_ready got %b want 010", req_ready); end
        @(negedge clk);
        set_req(1, 7'd6, 64'hB);
        #1;
        n_checks++; if (req_ready !== 3'b010) begin n_fail++; $display("FAIL b2b_second_ready got %b want 010", req_ready); end
        n_checks++; if (rf_wd !== 64'hA || free_rn !== 7'd6) begin n_fail++; $display("FAIL b2b_first_wb got %0h/free=%0d want a/free=6", rf_wd, free_rn); end
        @(negedge clk);
        req_valid = '0;
        #1;
        n_checks++; if (rf_wd !== 64'hB || free_rn !== 7'd6 || rf_we !== 1'b1) begin n_fail++; $display("FAIL b2b_second_wb got %0h/free=%0d/we=%0b want b/free=6/we=1", rf_wd, free_rn, rf_we); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_r0();
        test_fairness();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
